shift_sequencer: RTL and testbench
==================================

# shift_sequencer

Parametrised universal shift register with a command handshake and a multi-cycle shift sequencer. It replaces the fixed 4-bit register with single-bit `q0..q3` outputs. It adds WIDTH-bit parallel load, clear, logical, rotate and arithmetic shifts by a programmable count, serial in/out, and busy/done status. It sits between a command source (controller FSM or bench) and datapath logic that consumes `q`.

## Interface
- `WIDTH`, 4: register width in bits, ≥2.
- `CNT_W`, 8: width of the shift-count field.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command can be accepted; equals `!busy`.
- `cmd_op`  in  3  operation code (see Operation).
- `cmd_cnt`  in  CNT_W  shift count for shift/rotate ops.
- `load_data`  in  WIDTH  parallel load value.
- `ser_in`  in  1  serial fill bit, sampled on every shift edge.
- `q`  out  WIDTH  register contents.
- `ser_out`  out  1  last bit shifted or rotated out (registered).
- `busy`  out  1  multi-cycle shift in progress.
- `done`  out  1  one-cycle completion pulse (registered).

## Operation
- Opcodes:
  - 0 NOP.
  - 1 LOAD: `q`←`load_data`.
  - 2 CLR: `q`←0.
  - 3 SHL: `ser_in`→bit0.
  - 4 SHR: `ser_in`→MSB.
  - 5 ROL.
  - 6 ROR.
  - 7 ASR: MSB replicated.
- Accept occurs on a rising edge with `cmd_valid && cmd_ready`. Inputs are ignored when not accepted.
- States:
  - IDLE: `busy`=0.
  - SHIFT: `busy`=1, with a `remaining` down-counter of width CNT_W.
- NOP, LOAD, CLR, and shift ops with `cmd_cnt`=0:
  - LOAD/CLR update `q` on the accept edge; NOP and cnt=0 shifts leave `q` unchanged.
  - State stays IDLE; `done`=1 for the following cycle.
- Shift ops with `cmd_cnt`=N≥1:
  - The first one-position step is applied on the accept edge.
  - If N=1, stay IDLE and pulse `done`.
  - Otherwise enter SHIFT with `remaining`=N−1. Apply one step per edge and decrement `remaining`.
  - On the edge that applies the last step, return to IDLE; `done` is high the next cycle.
- N>WIDTH is legal. Steps simply continue; rotates wrap and shifts keep filling.
- `ser_out` on each step takes the bit leaving the register:
  - SHL/ROL: old `q[WIDTH-1]`.
  - SHR/ROR/ASR: old `q[0]`.
  - LOAD/CLR/NOP leave `ser_out` unchanged.
- Opcode, `ser_in` use and ASR sign come from the latched command. `ser_in` itself is sampled live on every step.

## Timing
- Reset values: `q`=0, `ser_out`=0, `busy`=0, `done`=0, `cmd_ready`=1, state IDLE, `remaining`=0.
- Latency:
  - Single-cycle ops: result visible 1 cycle after accept; `done` in that same cycle.
  - N-step shift: `q` changes on N consecutive edges starting at the accept edge. `busy` is high for N−1 cycles, then `done` is high for 1 cycle.
- `cmd_ready` is combinational from state and low throughout SHIFT. A command presented during `busy` is held off, not dropped, and is accepted on the first IDLE edge.
- Back-to-back: a command valid in the `done` cycle is accepted on that cycle's edge (zero bubble).
- `rst` dominates everything, including an accept on the same edge. Reset mid-SHIFT aborts the command: `q`=0, no `done`, IDLE on the next cycle.

## Structure
- Package `shift_sequencer_pkg`: opcode enum (`OP_NOP`…`OP_ASR`) and state enum (`ST_IDLE`, `ST_SHIFT`).
- Sub-module `shift_step`: combinational one-position step taking (q, op, ser_in) and returning (q_next, bit_out). It is instantiated once.
- Top level: FSM, `remaining` counter, latched op, and `q`/`ser_out`/`done` registers.

## Test plan
- WIDTH=4. Reset, then LOAD `1011` → `q`=`1011` next cycle, `done` pulses once, `ser_out`=0.
- `q`=`1011`, ROL cnt=1 → `q`=`0111`, `ser_out`=1, `busy` never high, `done` 1 cycle later.
- `q`=`1000`, SHR cnt=3 with `ser_in`=0 → `q` goes `0100`, `0010`, `0001` on 3 consecutive edges. `busy` is high 2 cycles and `cmd_ready` low throughout, then `done`. A second command (LOAD `1111`) is presented in the `done` cycle and gives `q`=`1111` one cycle later.
- `q`=`1000`, ASR cnt=2 → `1100` then `1110`. Separately, SHL cnt=0 → `q` unchanged, `done` next cycle.
- ROR cnt=5 on `0001` → final `q`=`1000` (wrap past WIDTH), `ser_out`=1.
- SHL cnt=6 from `0001`, `rst` asserted on the 3rd step edge → `q`=0, `busy`=0, `done` never asserts, `cmd_ready`=1.

Source files
------------

// File: rtl/shift_sequencer_pkg.sv
// Shared opcode/state encodings for the shift sequencer and its step datapath.
package shift_sequencer_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_LOAD = 3'd1,
    OP_CLR  = 3'd2,
    OP_SHL  = 3'd3,
    OP_SHR  = 3'd4,
    OP_ROL  = 3'd5,
    OP_ROR  = 3'd6,
    OP_ASR  = 3'd7
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  function automatic logic is_shift(op_e op);
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROL) ||
           (op == OP_ROR) || (op == OP_ASR);
  endfunction

endpackage

// File: rtl/shift_sequencer_step.sv
// Combinational one-position shift/rotate step; bit_out_o is the bit leaving the register.
module shift_step
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] q_i,
  input  op_e              op_i,
  input  logic             ser_in_i,
  output logic [WIDTH-1:0] q_next_o,
  output logic             bit_out_o
);

  always_comb begin
    q_next_o  = q_i;
    bit_out_o = 1'b0;
    case (op_i)
      OP_SHL: begin
        q_next_o  = {q_i[WIDTH-2:0], ser_in_i};
        bit_out_o = q_i[WIDTH-1];
      end
      OP_SHR: begin
        q_next_o  = {ser_in_i, q_i[WIDTH-1:1]};
        bit_out_o = q_i[0];
      end
      OP_ROL: begin
        q_next_o  = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
        bit_out_o = q_i[WIDTH-1];
      end
      OP_ROR: begin
        q_next_o  = {q_i[0], q_i[WIDTH-1:1]};
        bit_out_o = q_i[0];
      end
      OP_ASR: begin
        q_next_o  = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
        bit_out_o = q_i[0];
      end
      default: begin
        q_next_o  = q_i;
        bit_out_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Universal shift register with command handshake and multi-cycle shift sequencing.
//   state    | meaning
//   ST_IDLE  | ready for a command; single-cycle ops and first shift step happen here
//   ST_SHIFT | applying remaining steps of a latched shift, one per edge
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  state_e           state_q;
  logic [CNT_W-1:0] rem_q;
  op_e              op_q;
  logic [WIDTH-1:0] q_q;
  logic             ser_out_q;
  logic             done_q;

  op_e              cmd_op_e;
  op_e              step_op;
  logic [WIDTH-1:0] step_q;
  logic             step_bit;
  logic             accept;

  assign cmd_op_e  = op_e'(cmd_op);
  assign busy      = (state_q == ST_SHIFT);
  assign cmd_ready = !busy;
  assign accept    = cmd_valid && cmd_ready;
  // The first step uses the live opcode; later steps use the latched one.
  assign step_op   = busy ? op_q : cmd_op_e;

  assign q       = q_q;
  assign ser_out = ser_out_q;
  assign done    = done_q;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .q_i      (q_q),
    .op_i     (step_op),
    .ser_in_i (ser_in),
    .q_next_o (step_q),
    .bit_out_o(step_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rem_q     <= '0;
      op_q      <= OP_NOP;
      q_q       <= '0;
      ser_out_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (cmd_op_e == OP_LOAD) begin
              q_q    <= load_data;
              done_q <= 1'b1;
            end else if (cmd_op_e == OP_CLR) begin
              q_q    <= '0;
              done_q <= 1'b1;
            end else if (!is_shift(cmd_op_e) || cmd_cnt == '0) begin
              done_q <= 1'b1;
            end else begin
              q_q       <= step_q;
              ser_out_q <= step_bit;
              if (cmd_cnt == CNT_W'(1)) begin
                done_q <= 1'b1;
              end else begin
                state_q <= ST_SHIFT;
                rem_q   <= cmd_cnt - CNT_W'(1);
                op_q    <= cmd_op_e;
              end
            end
          end
        end
        ST_SHIFT: begin
          q_q       <= step_q;
          ser_out_q <= step_bit;
          if (rem_q == CNT_W'(1)) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            done_q  <= 1'b1;
          end else begin
            rem_q <= rem_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          rem_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed scoreboard bench for shift_sequencer at WIDTH=4.
module tb_shift_sequencer;
  import shift_sequencer_pkg::*;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [CNT_W-1:0] cmd_cnt;
  logic [WIDTH-1:0] load_data;
  logic             ser_in;
  logic [WIDTH-1:0] q;
  logic             ser_out;
  logic             busy;
  logic             done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic             so;
    logic             busy;
    logic             done;
    string            tag;
  } exp_t;

  exp_t sb[$];
  logic [WIDTH-1:0] mq;
  logic             mso;

  always #5 clk = ~clk;

  shift_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_cnt  (cmd_cnt),
    .load_data(load_data),
    .ser_in   (ser_in),
    .q        (q),
    .ser_out  (ser_out),
    .busy     (busy),
    .done     (done)
  );

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_pop();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check({e.tag, ".q"},     32'(q),         32'(e.q));
    check({e.tag, ".so"},    32'(ser_out),   32'(e.so));
    check({e.tag, ".busy"},  32'(busy),      32'(e.busy));
    check({e.tag, ".done"},  32'(done),      32'(e.done));
    check({e.tag, ".ready"}, 32'(cmd_ready), 32'(!e.busy));
  endtask

  task automatic push(string tag, logic b, logic d);
    exp_t e;
    e.q = mq; e.so = mso; e.busy = b; e.done = d; e.tag = tag;
    sb.push_back(e);
  endtask

  // Independent reference step, written from the opcode table.
  task automatic model_step(op_e op, logic sin);
    logic [WIDTH-1:0] o;
    o = mq;
    case (op)
      OP_SHL: begin mso = o[3]; mq = {o[2:0], sin};  end
      OP_SHR: begin mso = o[0]; mq = {sin, o[3:1]};  end
      OP_ROL: begin mso = o[3]; mq = {o[2:0], o[3]}; end
      OP_ROR: begin mso = o[0]; mq = {o[0], o[3:1]}; end
      OP_ASR: begin mso = o[0]; mq = {o[3], o[3:1]}; end
      default: ;
    endcase
  endtask

  // Drive one command at the current (post-edge) point, then check every cycle until it completes.
  task automatic do_cmd(op_e op, int cnt, logic [WIDTH-1:0] data, logic sin, string tag);
    if (op == OP_LOAD) begin
      mq = data; push(tag, 1'b0, 1'b1);
    end else if (op == OP_CLR) begin
      mq = '0; push(tag, 1'b0, 1'b1);
    end else if (op == OP_NOP || cnt == 0) begin
      push(tag, 1'b0, 1'b1);
    end else begin
      for (int k = 1; k <= cnt; k++) begin
        model_step(op, sin);
        push($sformatf("%s.s%0d", tag, k), k < cnt, k == cnt);
      end
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_cnt = CNT_W'(cnt);
    load_data = data; ser_in = sin;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = 3'd0; load_data = '0;
    check_pop();
    for (int g = 0; g < 64 && sb.size() > 0; g++) begin
      @(posedge clk); #1;
      check_pop();
    end
    if (sb.size() > 0) check("cmd_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic idle(int n, string tag);
    for (int i = 0; i < n; i++) begin
      push(tag, 1'b0, 1'b0);
      @(posedge clk); #1;
      check_pop();
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_cnt = '0;
    load_data = '0; ser_in = 1'b0;
    mq = '0; mso = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    push("reset", 1'b0, 1'b0);
    check_pop();
    rst = 1'b0;
    idle(1, "post_reset");

    do_cmd(OP_LOAD, 0, 4'b1011, 1'b0, "load1011");
    idle(1, "after_load");
    do_cmd(OP_ROL, 1, 4'b0000, 1'b0, "rol1");

    do_cmd(OP_LOAD, 0, 4'b1000, 1'b0, "load1000");
    do_cmd(OP_SHR, 3, 4'b0000, 1'b0, "shr3");
    // presented in the done cycle of shr3: zero-bubble accept
    do_cmd(OP_LOAD, 0, 4'b1111, 1'b0, "b2b_load");
    idle(1, "after_b2b");

    do_cmd(OP_LOAD, 0, 4'b1000, 1'b0, "load_asr");
    do_cmd(OP_ASR, 2, 4'b0000, 1'b0, "asr2");
    do_cmd(OP_SHL, 0, 4'b0000, 1'b1, "shl0");

    do_cmd(OP_LOAD, 0, 4'b0001, 1'b0, "load_ror");
    do_cmd(OP_ROR, 5, 4'b0000, 1'b0, "ror5");

    do_cmd(OP_LOAD, 0, 4'b0100, 1'b0, "load_shl");
    do_cmd(OP_SHL, 3, 4'b0000, 1'b1, "shl3_fill1");
    do_cmd(OP_SHR, 2, 4'b0000, 1'b1, "shr2_fill1");
    do_cmd(OP_NOP, 0, 4'b1010, 1'b0, "nop");
    do_cmd(OP_CLR, 0, 4'b0000, 1'b0, "clr");
    idle(1, "after_clr");

    // Reset on the third step edge of a 6-step shift aborts it.
    do_cmd(OP_LOAD, 0, 4'b0001, 1'b0, "load_rst");
    mq = 4'b0010; mso = 1'b0; push("rst_abort.s1", 1'b1, 1'b0);
    mq = 4'b0100; mso = 1'b0; push("rst_abort.s2", 1'b1, 1'b0);
    cmd_valid = 1'b1; cmd_op = OP_SHL; cmd_cnt = CNT_W'(6); ser_in = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = 3'd0;
    check_pop();
    @(posedge clk); #1;
    check_pop();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mq = '0; mso = 1'b0;
    push("rst_abort.r", 1'b0, 1'b0);
    check_pop();
    idle(3, "rst_abort.quiet");

    do_cmd(OP_LOAD, 0, 4'b0110, 1'b0, "load_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
